// File: rtl/ab_game_pkg.sv
// Shared types for the A/B guessing game: state codes, digit vector,
// default try limit and the digit-set validity check used by load and enter.
package ab_game_pkg;

    localparam int DIGIT_W           = 4;
    localparam int NUM_DIGITS        = 4;
    localparam int MAX_TRIES_DEFAULT = 7;

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_RESULT = 3'd4,
        ST_WIN    = 3'd5,
        ST_LOSE   = 3'd6
    } state_t;

    // Every digit must be decimal and all four must differ.
    function automatic logic digits_valid(input digit_vec_t d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (d[i] > DIGIT_W'(9))
                ok = 1'b0;
            for (int j = i + 1; j < NUM_DIGITS; j++)
                if (d[i] == d[j])
                    ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/ab_digit_cmp.sv
// One-position A/B decision: exact hit at idx, else hit on any other secret digit.
module ab_digit_cmp
    import ab_game_pkg::*;
(
    input  logic [DIGIT_W-1:0] guess_digit,
    input  logic [1:0]         idx,
    input  digit_vec_t         secret,
    output logic               a_hit,
    output logic               b_hit
);

    always_comb begin
        a_hit = (guess_digit == secret[idx]);
        b_hit = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++)
            if (2'(j) != idx && secret[j] == guess_digit)
                b_hit = 1'b1;
        if (a_hit)
            b_hit = 1'b0;
    end

endmodule

// File: rtl/guess_sequencer.sv
// A/B guessing-game sequencer: load secret, take guesses, score one digit per cycle.
// Define GUESS_LIMIT_EN to end a game in LOSE after MAX_TRIES wrong guesses.
module guess_sequencer #(
    parameter int MAX_TRIES = ab_game_pkg::MAX_TRIES_DEFAULT,
    parameter int DIGIT_W   = ab_game_pkg::DIGIT_W
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    input  logic               in_loadtest,
    input  logic               in_enter,
    input  logic               in_restart,
    input  logic [DIGIT_W-1:0] in_ans0,
    input  logic [DIGIT_W-1:0] in_ans1,
    input  logic [DIGIT_W-1:0] in_ans2,
    input  logic [DIGIT_W-1:0] in_ans3,
    output logic [2:0]         out_Anum,
    output logic [2:0]         out_Bnum,
    output logic [2:0]         out_state,
    output logic               out_valid,
    output logic               out_err,
    output logic [3:0]         out_tries
);
    import ab_game_pkg::*;

    if (DIGIT_W != ab_game_pkg::DIGIT_W || MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_param_chk
        $error("guess_sequencer: unsupported DIGIT_W or MAX_TRIES");
    end

    state_t     state_q, state_d;
    digit_vec_t ans, secret_q, guess_q;
    logic [1:0] idx_q;
    logic [2:0] acc_a, acc_b, anum_q, bnum_q;
    logic [3:0] tries_q;
    logic       valid_q, err_q;
    logic       ans_ok, a_hit, b_hit, lose_hit;
    logic       do_load, do_enter, bad_in;

    assign ans    = {in_ans3, in_ans2, in_ans1, in_ans0};
    assign ans_ok = digits_valid(ans);

`ifdef GUESS_LIMIT_EN
    assign lose_hit = (tries_q == 4'(MAX_TRIES));
`else
    assign lose_hit = 1'b0;
`endif

    ab_digit_cmp u_cmp (
        .guess_digit (guess_q[idx_q]),
        .idx         (idx_q),
        .secret      (secret_q),
        .a_hit       (a_hit),
        .b_hit       (b_hit)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        do_load  = 1'b0;
        do_enter = 1'b0;
        bad_in   = 1'b0;
        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (in_loadtest) begin
                    if (ans_ok) begin
                        do_load = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        bad_in = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (in_enter) begin
                    if (ans_ok) begin
                        do_enter = 1'b1;
                        state_d  = ST_CHECK;
                    end else begin
                        bad_in = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (idx_q == 2'd3)
                    state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (acc_a == 3'd4)
                    state_d = ST_WIN;
                else if (lose_hit)
                    state_d = ST_LOSE;
                else
                    state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
        // Restart overrides everything, including an in-flight check.
        if (in_restart) begin
            state_d  = ST_IDLE;
            do_load  = 1'b0;
            do_enter = 1'b0;
            bad_in   = 1'b0;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            secret_q <= '0;
            guess_q  <= '0;
            idx_q    <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            anum_q   <= '0;
            bnum_q   <= '0;
            tries_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (in_restart) begin
            secret_q <= '0;
            guess_q  <= '0;
            idx_q    <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            anum_q   <= '0;
            bnum_q   <= '0;
            tries_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= bad_in;
            if (do_load) begin
                secret_q <= ans;
                tries_q  <= '0;
                anum_q   <= '0;
                bnum_q   <= '0;
            end
            if (do_enter) begin
                guess_q <= ans;
                idx_q   <= '0;
                acc_a   <= '0;
                acc_b   <= '0;
                tries_q <= (tries_q == 4'd15) ? tries_q : tries_q + 4'd1;
            end
            if (state_q == ST_CHECK) begin
                acc_a <= acc_a + 3'(a_hit);
                acc_b <= acc_b + 3'(b_hit);
                idx_q <= idx_q + 2'd1;
            end
            // Result is published on the edge that leaves RESULT.
            if (state_q == ST_RESULT) begin
                valid_q <= 1'b1;
                anum_q  <= acc_a;
                bnum_q  <= acc_b;
            end
        end
    end

    assign out_state = state_q;
    assign out_Anum  = anum_q;
    assign out_Bnum  = bnum_q;
    assign out_tries = tries_q;
    assign out_valid = valid_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_guess_sequencer.sv
// Scoreboard bench for guess_sequencer: stimulus pushes expected valid/err
// events, a negedge monitor pops and compares them (including cycle of arrival).
module tb_guess_sequencer;
    import ab_game_pkg::*;

    localparam int TRIES_LIM = 2;

    logic       in_clk = 1'b0;
    logic       in_rst_n = 1'b0;
    logic       in_loadtest = 1'b0, in_enter = 1'b0, in_restart = 1'b0;
    logic [3:0] in_ans0 = '0, in_ans1 = '0, in_ans2 = '0, in_ans3 = '0;
    logic [2:0] out_Anum, out_Bnum, out_state;
    logic       out_valid, out_err;
    logic [3:0] out_tries;

    guess_sequencer #(.MAX_TRIES(TRIES_LIM), .DIGIT_W(4)) dut (
        .in_clk      (in_clk),
        .in_rst_n    (in_rst_n),
        .in_loadtest (in_loadtest),
        .in_enter    (in_enter),
        .in_restart  (in_restart),
        .in_ans0     (in_ans0),
        .in_ans1     (in_ans1),
        .in_ans2     (in_ans2),
        .in_ans3     (in_ans3),
        .out_Anum    (out_Anum),
        .out_Bnum    (out_Bnum),
        .out_state   (out_state),
        .out_valid   (out_valid),
        .out_err     (out_err),
        .out_tries   (out_tries)
    );

    always #5 in_clk = ~in_clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    always @(posedge in_clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] st;
        logic [3:0] tries;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input bit is_err, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] st, input logic [3:0] tries, input int lat);
        exp_t e;
        e.is_err = is_err;
        e.a      = a;
        e.b      = b;
        e.st     = st;
        e.tries  = tries;
        e.cyc    = cyc + lat;
        sb.push_back(e);
    endtask

    // Monitor: every valid/err cycle must match the head of the scoreboard.
    always @(negedge in_clk) begin
        if (in_rst_n && (out_valid || out_err)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: valid=%0b err=%0b at cycle %0d, none expected",
                         out_valid, out_err, cyc);
            end else begin
                mon_e = sb.pop_front();
                check(mon_e.is_err ? "err_event" : "result_event",
                      {17'd0, out_err, out_valid, out_Anum, out_Bnum, out_tries, out_state},
                      {17'd0, mon_e.is_err, !mon_e.is_err, mon_e.a, mon_e.b, mon_e.tries, mon_e.st});
                check("event_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Present inputs for exactly one sampling edge; returns at the following negedge.
    task automatic drive(input logic ld, input logic en,
                         input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3);
        in_loadtest = ld;
        in_enter    = en;
        in_ans0     = d0;
        in_ans1     = d1;
        in_ans2     = d2;
        in_ans3     = d3;
        @(negedge in_clk);
        in_loadtest = 1'b0;
        in_enter    = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge in_clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout with %0d events pending, required 0", name, sb.size());
            sb.delete();
        end
        repeat (2) @(negedge in_clk);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {17'd0, out_Anum, out_Bnum, out_state, out_valid, out_err, out_tries}, 32'd0);
    endtask

    logic [2:0] st_after_2nd;

    initial begin
`ifdef GUESS_LIMIT_EN
        st_after_2nd = ST_LOSE;
`else
        st_after_2nd = ST_WAIT;
`endif
        repeat (2) @(negedge in_clk);
        check_all_zero("reset_outputs");
        in_rst_n = 1'b1;
        @(negedge in_clk);

        // Invalid load in IDLE: one err pulse, state stays IDLE.
        push(1'b1, 3'd0, 3'd0, ST_IDLE, 4'd0, 1);
        drive(1'b1, 1'b0, 4'd1, 4'd1, 4'd2, 4'd3);
        drain("idle_bad_load");
        check("idle_after_bad_load", out_state, ST_IDLE);

        // Load 1,2,3,4 with enter also high: load wins, no check starts.
        drive(1'b1, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        check("load_state", out_state, ST_WAIT);
        check("load_tries", out_tries, 0);
        repeat (7) @(negedge in_clk);

        // Guess 2,3,4,5 -> A0 B3, valid N+5.
        push(1'b0, 3'd0, 3'd3, ST_WAIT, 4'd1, 6);
        drive(1'b0, 1'b1, 4'd2, 4'd3, 4'd4, 4'd5);
        drain("guess_2345");
        check("wait_after_result", out_state, ST_WAIT);

        // Invalid guesses: repeated digit, non-decimal digit.
        push(1'b1, 3'd0, 3'd3, ST_WAIT, 4'd1, 1);
        drive(1'b0, 1'b1, 4'd5, 4'd5, 4'd2, 4'd3);
        drain("bad_guess_dup");
        push(1'b1, 3'd0, 3'd3, ST_WAIT, 4'd1, 1);
        drive(1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 4'hA);
        drain("bad_guess_hex");
        check("tries_after_bad", out_tries, 1);

        // Second wrong guess with loadtest also high: A2 B2, LOSE only with the limit.
        push(1'b0, 3'd2, 3'd2, st_after_2nd, 4'd2, 6);
        drive(1'b1, 1'b1, 4'd1, 4'd3, 4'd2, 4'd4);
        drain("guess_1324");
        check("state_after_2nd", out_state, st_after_2nd);

        in_restart = 1'b1;
        @(negedge in_clk);
        in_restart = 1'b0;
        check_all_zero("restart_clears");

        // Winning guess, then a stray enter in WIN is ignored.
        drive(1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        push(1'b0, 3'd4, 3'd0, ST_WIN, 4'd1, 6);
        drive(1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        drain("guess_win");
        drive(1'b0, 1'b1, 4'd2, 4'd3, 4'd4, 4'd5);
        repeat (8) @(negedge in_clk);
        check("win_hold", {out_state, out_Anum, out_Bnum, out_tries}, {ST_WIN, 3'd4, 3'd0, 4'd1});

        // Reload from WIN clears results.
        drive(1'b1, 1'b0, 4'd9, 4'd8, 4'd7, 4'd6);
        check("reload_from_win", {out_state, out_Anum, out_Bnum, out_tries}, {ST_WAIT, 3'd0, 3'd0, 4'd0});

        // Restart during the second CHECK cycle: no result may appear.
        drive(1'b0, 1'b1, 4'd6, 4'd7, 4'd8, 4'd9);
        check("in_check", out_state, ST_CHECK);
        @(negedge in_clk);
        in_restart = 1'b1;
        @(negedge in_clk);
        in_restart = 1'b0;
        check_all_zero("restart_mid_check");
        repeat (8) @(negedge in_clk);
        check("idle_after_restart", out_state, ST_IDLE);

        // Async reset while in RESULT.
        drive(1'b1, 1'b0, 4'd9, 4'd8, 4'd7, 4'd6);
        drive(1'b0, 1'b1, 4'd6, 4'd7, 4'd8, 4'd9);
        repeat (4) @(negedge in_clk);
        check("in_result", {out_state, out_tries}, {ST_RESULT, 4'd1});
        #1 in_rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) @(negedge in_clk);
        in_rst_n = 1'b1;
        repeat (3) @(negedge in_clk);
        check("idle_after_reset", out_state, ST_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/guess_sequencer.md
GUESS_SEQUENCER -- requirements
Module: guess_sequencer

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 7, range 1-15: maximum guesses per game (used only when GUESS_LIMIT_EN is defined).
REQ-002 SHALL have parameter DIGIT_W, default 4: width of one decimal digit.
REQ-003 SHALL have port in_clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port in_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_loadtest, input, 1: load the secret from in_ans0..3.
REQ-006 SHALL have port in_enter, input, 1: submit a guess from in_ans0..3.
REQ-007 SHALL have port in_restart, input, 1: synchronous soft restart.
REQ-008 SHALL have ports in_ans0, in_ans1, in_ans2, in_ans3, input, DIGIT_W each: digit positions 0-3.
REQ-009 SHALL have ports out_Anum and out_Bnum, output, 3 each: exact-position and wrong-position match counts.
REQ-010 SHALL have port out_state, output, 3: current FSM state code.
REQ-011 SHALL have port out_valid, output, 1: result strobe.
REQ-012 SHALL have port out_err, output, 1: invalid-input strobe.
REQ-013 SHALL have port out_tries, output, 4: guesses consumed in the current game.

Function
REQ-014 SHALL encode states as IDLE=0, WAIT=2, CHECK=3, RESULT=4, WIN=5, LOSE=6; codes 1 and 7 are unused and SHALL recover to IDLE.
REQ-015 SHALL treat a digit set as valid only if every digit is 0-9 and all four digits are pairwise distinct.
REQ-016 In IDLE, WIN or LOSE, in_loadtest=1 with a valid set SHALL register the secret, clear out_tries, out_Anum and out_Bnum, and go to WAIT on the next cycle.
REQ-017 In IDLE, WIN or LOSE, in_loadtest=1 with an invalid set SHALL pulse out_err for one cycle and leave the state unchanged.
REQ-018 In WAIT, in_enter=1 with a valid set SHALL register the guess, increment out_tries, and go to CHECK.
REQ-019 In WAIT, in_enter=1 with an invalid set SHALL pulse out_err and leave out_tries unchanged.
REQ-020 CHECK SHALL last exactly 4 cycles, with index i=0..3.
REQ-021 In each CHECK cycle, if guess[i]==secret[i] the A accumulator SHALL increment; else if guess[i] equals any other secret digit the B accumulator SHALL increment.
REQ-022 After CHECK, RESULT SHALL last exactly 1 cycle: out_valid=1, and out_Anum/out_Bnum SHALL update with the accumulators.
REQ-023 Latency: in_enter sampled at edge N SHALL give out_valid=1 in the cycle following edge N+5.
REQ-024 After RESULT: A==4 SHALL go to WIN; otherwise the limit check of REQ-031 SHALL apply; otherwise the next state SHALL be WAIT.
REQ-025 out_Anum and out_Bnum SHALL hold the last result until the next RESULT, load or restart.
REQ-026 in_enter SHALL be ignored outside WAIT; in_loadtest SHALL be ignored in WAIT, CHECK and RESULT.
REQ-027 If in_loadtest and in_enter are asserted together, the one legal in the current state SHALL act; the other SHALL be ignored.
REQ-028 in_restart=1 SHALL have top priority in any state, including mid-CHECK: next state IDLE, all outputs and registers cleared, accumulators discarded, no out_valid.

Reset
REQ-029 in_rst_n=0 SHALL asynchronously force state IDLE, secret and guess to 0, and every output to 0.

Configuration
REQ-030 Macro GUESS_LIMIT_EN SHALL compile the try limit in or out.
REQ-031 With GUESS_LIMIT_EN defined: at RESULT with A!=4 and out_tries==MAX_TRIES, the next state SHALL be LOSE.
REQ-032 Without GUESS_LIMIT_EN: LOSE is unreachable; out_tries SHALL saturate at 15 and guesses are unlimited.

Structure
REQ-033 Package ab_game_pkg SHALL hold the state enum/codes, DIGIT_W, digit vector typedef, and the default MAX_TRIES constant.
REQ-034 Sub-module ab_digit_cmp SHALL be the combinational one-position A/B decision (guess digit, index, secret vector -> a_hit, b_hit).
REQ-035 The validity check SHALL be a package function shared by the load and enter paths.

Verification
REQ-036 Load secret 1,2,3,4, then guess 2,3,4,5 -> out_valid at edge N+5 with A=0, B=3, out_tries=1, next state WAIT.
REQ-037 Same secret, guess 1,2,3,4 -> A=4, B=0, state WIN; a later in_enter is ignored.
REQ-038 In WAIT, guess 5,5,2,3 or 1,2,3,A -> out_err single-cycle pulse, out_tries unchanged, state WAIT.
REQ-039 Assert in_restart on the 2nd CHECK cycle -> IDLE next cycle, outputs 0, no out_valid pulse.
REQ-040 With GUESS_LIMIT_EN and MAX_TRIES=2, two wrong guesses -> LOSE after the second RESULT; without the macro -> WAIT.
REQ-041 Drop in_rst_n mid-RESULT -> all outputs 0 immediately, without waiting for a clock edge.
